// File: rtl/bus_pkg.sv
// Shared types for the memory bus arbiter and its round-robin picker.
package bus_pkg;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [MASK_W-1:0] mask_t;

  typedef enum logic {
    FREE,
    OWNED
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, cyclic.
module rr_pick #(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    int unsigned j;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!valid_o && req_i[IW'(j)]) begin
        valid_o         = 1'b1;
        gnt_o[IW'(j)]   = 1'b1;
        idx_o           = IW'(j);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for a shared single-port memory bus with bounded locked
// ownership and one-cycle read return routed back to the issuing master.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned NM       = 2,
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NM-1:0]      m_req,
  input  logic [NM-1:0]      m_lock,
  input  logic [NM*30-1:0]   m_addr,
  input  logic [NM*32-1:0]   m_data_w,
  input  logic [NM*4-1:0]    m_mask_w,
  output logic [NM-1:0]      m_gnt,
  output logic [NM-1:0]      m_rvalid,
  output word_t              m_data_r,
  output addr_t              bus_addr,
  output word_t              bus_data_w,
  output mask_t              bus_mask_w,
  input  word_t              bus_data_r
);

  localparam int unsigned PW = $clog2(NM);
  localparam int unsigned HW = $clog2(HOLD_MAX + 1);

  arb_state_t    state_q, state_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          rd_vld_q, rd_vld_d;
  logic [PW-1:0] rd_idx_q, rd_idx_d;

  logic [NM-1:0] pick_gnt;
  logic [PW-1:0] pick_idx;
  logic          pick_vld;

  logic          gnt_vld;
  logic [PW-1:0] gnt_idx;

  rr_pick #(.N(NM)) u_pick (
    .req_i   (m_req),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_vld)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= FREE;
      owner_q  <= '0;
      ptr_q    <= '0;
      hold_q   <= '0;
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      rd_vld_q <= rd_vld_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  // Reset also masks the combinational grant and the pending read return.
  always_comb begin
    m_gnt      = '0;
    gnt_vld    = 1'b0;
    gnt_idx    = '0;
    if (!reset) begin
      unique case (state_q)
        FREE: begin
          m_gnt   = pick_gnt;
          gnt_vld = pick_vld;
          gnt_idx = pick_idx;
        end
        OWNED: begin
          m_gnt[owner_q] = m_req[owner_q];
          gnt_vld        = m_req[owner_q];
          gnt_idx        = owner_q;
        end
        default: ;
      endcase
    end

    bus_addr   = '0;
    bus_data_w = '0;
    bus_mask_w = '0;
    if (gnt_vld) begin
      bus_addr   = m_addr[32'(gnt_idx)*ADDR_W +: ADDR_W];
      bus_data_w = m_data_w[32'(gnt_idx)*DATA_W +: DATA_W];
      bus_mask_w = m_mask_w[32'(gnt_idx)*MASK_W +: MASK_W];
    end

    m_rvalid = '0;
    if (rd_vld_q && !reset) m_rvalid[rd_idx_q] = 1'b1;
    m_data_r = bus_data_r;
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    rd_vld_d = gnt_vld && (bus_mask_w == '0);
    rd_idx_d = gnt_idx;
    unique case (state_q)
      FREE: begin
        if (gnt_vld) begin
          ptr_d = (gnt_idx == PW'(NM - 1)) ? '0 : gnt_idx + 1'b1;
          // A single-cycle hold limit means the lock can never extend ownership.
          if (m_lock[gnt_idx] && (HOLD_MAX > 1)) begin
            state_d = OWNED;
            owner_d = gnt_idx;
            hold_d  = HW'(1);
          end
        end
      end
      OWNED: begin
        if (!m_req[owner_q] || !m_lock[owner_q] ||
            (32'(hold_q) + 32'd1 >= HOLD_MAX)) begin
          state_d = FREE;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = FREE;
        hold_d  = '0;
      end
    endcase
  end

endmodule
